// File: rtl/tt_um_nibble_demux.sv
// Nibble demux: steers tagged nibbles into lanes A/B and rebuilds bytes (low nibble then high); uo_out shows the selected lane.
// Latency: a strobe edge sampled at clock edge N takes effect after edge N, or SYNC_STAGES edges later when NIBBLE_DEMUX_SYNC_EN is defined.
// Backpressure: none; a write to a FULL lane is dropped and raises the sticky overflow flag.
module tt_um_nibble_demux #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOW   = 2'd1,
    FULL  = 2'd2
  } lane_st_e;

  typedef struct packed {
    lane_st_e   st;
    logic [7:0] dat;
  } lane_t;

  // Control bits in one vector: {clr, wr, half, lane, pop, rd}
  logic [5:0] ctl_raw;
  logic [5:0] ctl;

  assign ctl_raw = {ui_in[7:4], uio_in[1:0]};

`ifdef NIBBLE_DEMUX_SYNC_EN
  logic [5:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= ctl_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign ctl = sync_q[SYNC_STAGES-1];
`else
  localparam int unused_sync_stages = SYNC_STAGES;
  assign ctl = ctl_raw;
`endif

  logic       clr;
  logic       wr_lvl;
  logic       wr_half;
  logic       wr_lane;
  logic       pop_lvl;
  logic       rd_sel;
  logic [3:0] nib;

  assign clr     = ctl[5];
  assign wr_lvl  = ctl[4];
  assign wr_half = ctl[3];
  assign wr_lane = ctl[2];
  assign pop_lvl = ctl[1];
  assign rd_sel  = ctl[0];
  assign nib     = ui_in[3:0];

  logic wr_prev;
  logic pop_prev;
  logic wr_ev;
  logic pop_ev;

  assign wr_ev  = wr_lvl & ~wr_prev;
  assign pop_ev = pop_lvl & ~pop_prev;

  lane_t lane_q [2];
  lane_t lane_d [2];
  logic  ovf_q;
  logic  ovf_d;
  logic  seq_q;
  logic  seq_d;
  lane_t cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev   <= 1'b0;
      pop_prev  <= 1'b0;
      lane_q[0] <= '{st: EMPTY, dat: 8'h00};
      lane_q[1] <= '{st: EMPTY, dat: 8'h00};
      ovf_q     <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      wr_prev   <= wr_lvl;
      pop_prev  <= pop_lvl;
      lane_q[0] <= lane_d[0];
      lane_q[1] <= lane_d[1];
      ovf_q     <= ovf_d;
      seq_q     <= seq_d;
    end
  end

  // Pop is resolved before the write so a same-edge pop+write on a FULL lane
  // lands the write into the freshly emptied lane.
  always_comb begin
    lane_d[0] = lane_q[0];
    lane_d[1] = lane_q[1];
    ovf_d     = ovf_q;
    seq_d     = seq_q;
    cur       = '0;
    if (clr) begin
      lane_d[0] = '{st: EMPTY, dat: 8'h00};
      lane_d[1] = '{st: EMPTY, dat: 8'h00};
      ovf_d     = 1'b0;
      seq_d     = 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        cur = lane_q[l];
        if (pop_ev && (rd_sel == 1'(l))) begin
          if (cur.st == FULL) begin
            cur = '{st: EMPTY, dat: 8'h00};
          end else begin
            seq_d = 1'b1;
          end
        end
        if (wr_ev && (wr_lane == 1'(l))) begin
          case (cur.st)
            EMPTY: begin
              if (!wr_half) begin
                cur = '{st: LOW, dat: {4'h0, nib}};
              end else begin
                seq_d = 1'b1;
              end
            end
            LOW: begin
              if (!wr_half) begin
                cur.dat[3:0] = nib;
              end else begin
                cur.dat[7:4] = nib;
                cur.st       = FULL;
              end
            end
            FULL: begin
              ovf_d = 1'b1;
            end
            default: begin
              cur = '{st: EMPTY, dat: 8'h00};
            end
          endcase
        end
        lane_d[l] = cur;
      end
    end
  end

  assign uo_out  = lane_q[rd_sel].dat;
  assign uio_out = {seq_q, ovf_q, (lane_q[1].st == FULL), (lane_q[0].st == FULL), 4'h0};
  assign uio_oe  = 8'hF0;

  logic unused;
  assign unused = &{1'b0, ena, uio_in[7:2]};

endmodule
